// File: rtl/coffee_dispense_ctrl.sv
// ----------------------------------------------------------------------------
// coffee_dispense_ctrl
//
// Dispense sequencer that sits behind the coin-acceptor FSM. Paid vends are
// queued in a small backlog counter; drinks are then run one at a time through
// cup drop, water heating, brewing and cup pickup. A heater that never reports
// hot water within the timeout parks the machine in a latched FAULT state
// until the operator clears it.
//
// Ports:
//   clock        sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   vend         paid-drink strobe; every sampled-high cycle is one vend
//   water_hot    boiler at temperature (level)
//   cup_taken    cup removed from tray (level)
//   clear_fault  operator fault acknowledge (level, only honoured in FAULT)
//   cup_drop     cup dispenser actuator (CUP)
//   heater_on    boiler heater (HEAT or BREW)
//   pump_on      brew pump (BREW)
//   ready        drink ready lamp (DONE)
//   busy         any state other than IDLE
//   fault        heater fault lamp (FAULT)
//   overflow     one-cycle pulse when a vend was dropped on a full backlog
//   pending      current backlog count
// ----------------------------------------------------------------------------
module coffee_dispense_ctrl #(
    parameter int CUP_CYCLES   = 4,
    parameter int BREW_CYCLES  = 16,
    parameter int HEAT_TIMEOUT = 64,
    parameter int MAX_PENDING  = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       vend,
    input  logic       water_hot,
    input  logic       cup_taken,
    input  logic       clear_fault,
    output logic       cup_drop,
    output logic       heater_on,
    output logic       pump_on,
    output logic       ready,
    output logic       busy,
    output logic       fault,
    output logic       overflow,
    output logic [3:0] pending
);

    localparam int MAX_LEN_CB = (CUP_CYCLES > BREW_CYCLES) ? CUP_CYCLES : BREW_CYCLES;
    localparam int MAX_LEN    = (MAX_LEN_CB > HEAT_TIMEOUT) ? MAX_LEN_CB : HEAT_TIMEOUT;
    localparam int CNT_W      = $clog2(MAX_LEN + 1);

    // The counter is loaded with N-1 so that a state is left on the cycle
    // the counter is seen at zero, giving exactly N cycles in that state.
    localparam logic [CNT_W-1:0] CUP_LOAD  = CNT_W'(CUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HEAT_LOAD = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BREW_LOAD = CNT_W'(BREW_CYCLES - 1);
    localparam logic [3:0]       PEND_MAX  = 4'(MAX_PENDING);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CUP   = 3'd1,
        HEAT  = 3'd2,
        BREW  = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             start;
    logic             accept;

    // A start frees one backlog slot in the same cycle, so a vend arriving
    // on a full backlog is still accepted when a drink is being started.
    assign start  = (state == IDLE) && (pending != 4'd0);
    assign accept = vend && ((pending < PEND_MAX) || start);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CUP;
                    cnt_nx   = CUP_LOAD;
                end
            end
            CUP: begin
                if (cnt == '0) begin
                    state_nx = HEAT;
                    cnt_nx   = HEAT_LOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            HEAT: begin
                // Hot water wins over a timeout expiring in the same cycle.
                if (water_hot) begin
                    state_nx = BREW;
                    cnt_nx   = BREW_LOAD;
                end else if (cnt == '0) begin
                    state_nx = FAULT;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            BREW: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                if (cup_taken) begin
                    state_nx = IDLE;
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they always match the state register exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= 4'd0;
            overflow  <= 1'b0;
            cup_drop  <= 1'b0;
            heater_on <= 1'b0;
            pump_on   <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pending   <= pending + 4'(accept) - 4'(start);
            overflow  <= vend && !accept;
            cup_drop  <= (state_nx == CUP);
            heater_on <= (state_nx == HEAT) || (state_nx == BREW);
            pump_on   <= (state_nx == BREW);
            ready     <= (state_nx == DONE);
            busy      <= (state_nx != IDLE);
            fault     <= (state_nx == FAULT);
        end
    end

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// ----------------------------------------------------------------------------
// tb_coffee_dispense_ctrl
//
// Directed scenarios followed by a randomized phase, all compared every cycle
// against a behavioural model of the dispense sequence (phase plus elapsed
// cycle count, backlog as an integer).
// ----------------------------------------------------------------------------
module tb_coffee_dispense_ctrl;

    localparam int CUP_N  = 4;
    localparam int BREW_N = 16;
    localparam int HEAT_N = 64;
    localparam int MAXP   = 3;

    localparam int P_IDLE  = 0;
    localparam int P_CUP   = 1;
    localparam int P_HEAT  = 2;
    localparam int P_BREW  = 3;
    localparam int P_DONE  = 4;
    localparam int P_FAULT = 5;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       vend = 1'b0;
    logic       water_hot = 1'b0;
    logic       cup_taken = 1'b0;
    logic       clear_fault = 1'b0;
    logic       cup_drop;
    logic       heater_on;
    logic       pump_on;
    logic       ready;
    logic       busy;
    logic       fault;
    logic       overflow;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_phase   = P_IDLE;
    int m_elapsed = 0;
    int m_pend    = 0;
    bit m_ovf     = 1'b0;

    coffee_dispense_ctrl #(
        .CUP_CYCLES  (CUP_N),
        .BREW_CYCLES (BREW_N),
        .HEAT_TIMEOUT(HEAT_N),
        .MAX_PENDING (MAXP)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .vend       (vend),
        .water_hot  (water_hot),
        .cup_taken  (cup_taken),
        .clear_fault(clear_fault),
        .cup_drop   (cup_drop),
        .heater_on  (heater_on),
        .pump_on    (pump_on),
        .ready      (ready),
        .busy       (busy),
        .fault      (fault),
        .overflow   (overflow),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_elapsed = 0;
        m_pend    = 0;
        m_ovf     = 1'b0;
    endtask

    // One rising edge of the drink sequence, from the rules in words.
    task automatic model_step();
        bit starting;
        bit taken;
        starting = (m_phase == P_IDLE) && (m_pend > 0);
        taken    = vend && ((m_pend < MAXP) || starting);
        m_pend   = m_pend + (taken ? 1 : 0) - (starting ? 1 : 0);
        m_ovf    = vend && !taken;
        case (m_phase)
            P_IDLE: if (starting) begin m_phase = P_CUP; m_elapsed = 0; end
            P_CUP: begin
                m_elapsed++;
                if (m_elapsed == CUP_N) begin m_phase = P_HEAT; m_elapsed = 0; end
            end
            P_HEAT: begin
                if (water_hot) begin
                    m_phase = P_BREW; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == HEAT_N) begin m_phase = P_FAULT; m_elapsed = 0; end
                end
            end
            P_BREW: begin
                m_elapsed++;
                if (m_elapsed == BREW_N) begin m_phase = P_DONE; m_elapsed = 0; end
            end
            P_DONE:  if (cup_taken) m_phase = P_IDLE;
            P_FAULT: if (clear_fault) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        chk("cup_drop",  32'(cup_drop),  32'(m_phase == P_CUP));
        chk("heater_on", 32'(heater_on), 32'((m_phase == P_HEAT) || (m_phase == P_BREW)));
        chk("pump_on",   32'(pump_on),   32'(m_phase == P_BREW));
        chk("ready",     32'(ready),     32'(m_phase == P_DONE));
        chk("busy",      32'(busy),      32'(m_phase != P_IDLE));
        chk("fault",     32'(fault),     32'(m_phase == P_FAULT));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("pending",   32'(pending),   32'(m_pend));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic run_until_idle_empty(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy && pending == 4'd0) break;
            cycle();
        end
        chk(tag, 32'(busy || (pending != 4'd0)), 32'd0);
    endtask

    task automatic wait_pump(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (pump_on) break;
            cycle();
        end
        chk(tag, 32'(pump_on), 32'd1);
    endtask

    initial begin
        int cup_n, heat_n, pump_n, ovf_n, starts;
        logic prev_cup;

        // Reset state
        repeat (2) @(negedge clock);
        model_reset();
        check_outputs();
        reset_n = 1'b1;

        // Single drink with hot water
        water_hot = 1'b1;
        vend = 1'b1;
        cycle();
        chk("t1_pend_after_vend", 32'(pending), 32'd1);
        vend = 1'b0;
        cup_n = 0; heat_n = 0; pump_n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (ready) break;
            if (cup_drop) cup_n++;
            if (heater_on && !pump_on) heat_n++;
            if (pump_on) pump_n++;
        end
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_cup_cycles", 32'(cup_n), 32'd4);
        chk("t1_heat_cycles", 32'(heat_n), 32'd1);
        chk("t1_pump_cycles", 32'(pump_n), 32'd16);
        repeat (3) cycle();
        chk("t1_ready_held", 32'(ready), 32'd1);
        cup_taken = 1'b1;
        cycle();
        chk("t1_busy_after_take", 32'(busy), 32'd0);
        cup_taken = 1'b0;

        // Heater timeout into FAULT
        water_hot = 1'b0;
        vend = 1'b1;
        cycle();
        vend = 1'b0;
        repeat (CUP_N + HEAT_N) cycle();
        chk("t2_no_fault_yet", 32'(fault), 32'd0);
        cycle();
        chk("t2_fault", 32'(fault), 32'd1);
        chk("t2_actuators_off", 32'({cup_drop, heater_on, pump_on}), 32'd0);
        vend = 1'b1;
        cycle();
        vend = 1'b0;
        chk("t2_pend_in_fault", 32'(pending), 32'd1);
        cycle();
        chk("t2_fault_latched", 32'(fault), 32'd1);
        clear_fault = 1'b1;
        cycle();
        clear_fault = 1'b0;
        chk("t2_idle_after_clear", 32'(busy), 32'd0);
        cycle();
        chk("t2_restart_cup", 32'(cup_drop), 32'd1);
        water_hot = 1'b1;
        cup_taken = 1'b1;
        run_until_idle_empty("t2_drain", 100);
        cup_taken = 1'b0;

        // Backlog overflow while brewing
        vend = 1'b1;
        cycle();
        vend = 1'b0;
        wait_pump("t3_reach_brew");
        vend = 1'b1;
        ovf_n = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (overflow) ovf_n++;
        end
        vend = 1'b0;
        chk("t3_pend_full", 32'(pending), 32'd3);
        chk("t3_overflow_pulses", 32'(ovf_n), 32'd2);
        cup_taken = 1'b1;
        starts = 0;
        prev_cup = cup_drop;
        for (int i = 0; i < 300; i++) begin
            if (!busy && pending == 4'd0) break;
            cycle();
            if (cup_drop && !prev_cup) starts++;
            prev_cup = cup_drop;
        end
        chk("t3_drained", 32'(busy || (pending != 4'd0)), 32'd0);
        chk("t3_three_drinks", 32'(starts), 32'd3);

        // Vend coinciding with IDLE->CUP
        vend = 1'b1;
        cycle();
        chk("t4_pend_one", 32'(pending), 32'd1);
        cycle();
        vend = 1'b0;
        chk("t4_pend_stays", 32'(pending), 32'd1);
        chk("t4_started", 32'(cup_drop), 32'd1);
        run_until_idle_empty("t4_drain", 200);
        cup_taken = 1'b0;

        // Asynchronous reset mid-BREW
        vend = 1'b1;
        cycle();
        vend = 1'b0;
        wait_pump("t5_reach_brew");
        vend = 1'b1;
        repeat (2) cycle();
        vend = 1'b0;
        cycle();
        chk("t5_pend_two", 32'(pending), 32'd2);
        chk("t5_in_brew", 32'(pump_on), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_outputs", 32'({cup_drop, heater_on, pump_on, ready, busy, fault, overflow}), 32'd0);
        chk("t5_async_pending", 32'(pending), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle();
        chk("t5_idle_after", 32'(busy), 32'd0);
        chk("t5_pend_after", 32'(pending), 32'd0);

        // Water becomes hot in HEAT cycle 10
        water_hot = 1'b0;
        vend = 1'b1;
        cycle();
        vend = 1'b0;
        repeat (CUP_N + 10) cycle();
        chk("t6_in_heat", 32'({heater_on, pump_on}), 32'b10);
        water_hot = 1'b1;
        cycle();
        chk("t6_brew", 32'(pump_on), 32'd1);
        chk("t6_no_fault", 32'(fault), 32'd0);
        cup_taken = 1'b1;
        run_until_idle_empty("t6_drain", 100);
        cup_taken = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            vend        = ($urandom_range(0, 5) == 0);
            cup_taken   = ($urandom_range(0, 3) == 0);
            clear_fault = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) water_hot = ~water_hot;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
